// File: rtl/jtag_tap_pkg.sv
// rtl/jtag_tap_pkg.sv - shared types and constants for the JTAG debug TAP
//
// Contents:
//   tap_state_e            16-state IEEE 1149.1 TAP controller state
//   BYPASS0..BYPASS1       5-bit instruction codes
//   IrCaptureValue         pattern loaded into the IR shift register in CaptureIr
//   Dtmcs*                 dtmcs field offsets
//   dtmcs_capture()        dtmcs word presented in CaptureDr
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TestLogicReset,
    RunTestIdle,
    SelectDrScan,
    CaptureDr,
    ShiftDr,
    Exit1Dr,
    PauseDr,
    Exit2Dr,
    UpdateDr,
    SelectIrScan,
    CaptureIr,
    ShiftIr,
    Exit1Ir,
    PauseIr,
    Exit2Ir,
    UpdateIr
  } tap_state_e;

  localparam logic [4:0] BYPASS0   = 5'h00;
  localparam logic [4:0] IDCODE    = 5'h01;
  localparam logic [4:0] DTMCS     = 5'h10;
  localparam logic [4:0] DMIACCESS = 5'h11;
  localparam logic [4:0] BYPASS1   = 5'h1F;

  localparam logic [4:0] IrCaptureValue = 5'b00101;

  localparam int unsigned DtmcsVersionLsb      = 0;
  localparam int unsigned DtmcsAbitsLsb        = 4;
  localparam int unsigned DtmcsDmistatLsb      = 10;
  localparam int unsigned DtmcsIdleLsb         = 12;
  localparam int unsigned DtmcsDmiresetBit     = 16;
  localparam int unsigned DtmcsDmihardresetBit = 17;

  // Read view of dtmcs: dmireset/dmihardreset always read back as 0.
  function automatic logic [31:0] dtmcs_capture(input logic [1:0] dmistat);
    logic [31:0] w;
    w = '0;
    w[DtmcsVersionLsb +: 4] = 4'd1;
    w[DtmcsAbitsLsb   +: 6] = 6'd7;
    w[DtmcsDmistatLsb +: 2] = dmistat;
    w[DtmcsIdleLsb    +: 3] = 3'd1;
    return w;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - IEEE 1149.1 TAP state machine with state decodes
//
// Ports:
//   tck_i, trst_ni     JTAG clock, synchronous active-low reset
//   tms_i              mode select, sampled on every rising edge
//   *_o                one-hot decodes of the current state
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic tck_i,
  input  logic trst_ni,
  input  logic tms_i,
  output logic test_logic_reset_o,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic update_dr_o,
  output logic capture_ir_o,
  output logic shift_ir_o,
  output logic update_ir_o
);

  tap_state_e state_q, state_d;

  always_ff @(posedge tck_i) begin
    if (!trst_ni) state_q <= TestLogicReset;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    test_logic_reset_o = 1'b0;
    capture_dr_o       = 1'b0;
    shift_dr_o         = 1'b0;
    update_dr_o        = 1'b0;
    capture_ir_o       = 1'b0;
    shift_ir_o         = 1'b0;
    update_ir_o        = 1'b0;
    unique case (state_q)
      TestLogicReset: begin
        test_logic_reset_o = 1'b1;
        state_d = tms_i ? TestLogicReset : RunTestIdle;
      end
      RunTestIdle:  state_d = tms_i ? SelectDrScan : RunTestIdle;
      SelectDrScan: state_d = tms_i ? SelectIrScan : CaptureDr;
      CaptureDr: begin
        capture_dr_o = 1'b1;
        state_d = tms_i ? Exit1Dr : ShiftDr;
      end
      ShiftDr: begin
        shift_dr_o = 1'b1;
        state_d = tms_i ? Exit1Dr : ShiftDr;
      end
      Exit1Dr: state_d = tms_i ? UpdateDr : PauseDr;
      PauseDr: state_d = tms_i ? Exit2Dr : PauseDr;
      Exit2Dr: state_d = tms_i ? UpdateDr : ShiftDr;
      UpdateDr: begin
        update_dr_o = 1'b1;
        state_d = tms_i ? SelectDrScan : RunTestIdle;
      end
      SelectIrScan: state_d = tms_i ? TestLogicReset : CaptureIr;
      CaptureIr: begin
        capture_ir_o = 1'b1;
        state_d = tms_i ? Exit1Ir : ShiftIr;
      end
      ShiftIr: begin
        shift_ir_o = 1'b1;
        state_d = tms_i ? Exit1Ir : ShiftIr;
      end
      Exit1Ir: state_d = tms_i ? UpdateIr : PauseIr;
      PauseIr: state_d = tms_i ? Exit2Ir : PauseIr;
      Exit2Ir: state_d = tms_i ? UpdateIr : ShiftIr;
      UpdateIr: begin
        update_ir_o = 1'b1;
        state_d = tms_i ? SelectDrScan : RunTestIdle;
      end
      default: state_d = TestLogicReset;
    endcase
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// rtl/jtag_tap_ctrl.sv - JTAG TAP with IDCODE, BYPASS, DTMCS and DMIACCESS registers
//
// Parameters: IrLength (IR width), IdcodeValue (IDCODE capture, bit 0 forced 1)
// Optional feature macro: JTAG_TAP_DMIHARDRESET_EN (dtmcs.dmihardreset honoured)
// Ports:
//   tck_i, trst_ni           JTAG clock, synchronous active-low reset
//   tms_i, td_i, td_o        TAP mode select, serial in, registered serial out
//   tdo_oe_o, testmode_i     registered td_o enable, scan mode forces enable
//   test_logic_reset_o, capture_dr_o, shift_dr_o, update_dr_o   state decodes
//   dmi_access_o, dtmcs_select_o   instruction decodes
//   dmi_reset_o              one-cycle dmireset pulse
//   dmi_error_i              dmistat reported through dtmcs
//   dmi_tdi_o, dmi_tdo_i     serial path to/from the external DMI register
module jtag_tap_ctrl
  import jtag_tap_pkg::*;
#(
  parameter int unsigned IrLength    = 5,
  parameter logic [31:0] IdcodeValue = 32'h00000001
) (
  input  logic       tck_i,
  input  logic       trst_ni,
  input  logic       tms_i,
  input  logic       td_i,
  output logic       td_o,
  output logic       tdo_oe_o,
  input  logic       testmode_i,
  output logic       test_logic_reset_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o,
  output logic       dmi_access_o,
  output logic       dtmcs_select_o,
  output logic       dmi_reset_o,
  input  logic [1:0] dmi_error_i,
  output logic       dmi_tdi_o,
  input  logic       dmi_tdo_i
);

  logic tlr, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir;

  jtag_tap_fsm u_fsm (
    .tck_i              (tck_i),
    .trst_ni            (trst_ni),
    .tms_i              (tms_i),
    .test_logic_reset_o (tlr),
    .capture_dr_o       (cap_dr),
    .shift_dr_o         (sh_dr),
    .update_dr_o        (upd_dr),
    .capture_ir_o       (cap_ir),
    .shift_ir_o         (sh_ir),
    .update_ir_o        (upd_ir)
  );

  logic [IrLength-1:0] ir_q, ir_shift_q;
  logic [31:0]         dr_q;
  logic                bypass_q, td_q, oe_q, dmi_reset_q;
  logic                sel_idcode, sel_dtmcs, sel_dmi, dr_tdo;

  // Unlisted codes fall through to BYPASS.
  always_comb begin
    sel_idcode = 1'b0;
    sel_dtmcs  = 1'b0;
    sel_dmi    = 1'b0;
    case (ir_q)
      IrLength'(IDCODE):    sel_idcode = 1'b1;
      IrLength'(DTMCS):     sel_dtmcs  = 1'b1;
      IrLength'(DMIACCESS): sel_dmi    = 1'b1;
      IrLength'(BYPASS0),
      IrLength'(BYPASS1):   ;
      default:              ;
    endcase
  end

  // The DMI register lives downstream, so DMIACCESS takes its LSB directly.
  always_comb begin
    dr_tdo = bypass_q;
    if (sel_dmi)                      dr_tdo = dmi_tdo_i;
    else if (sel_idcode || sel_dtmcs) dr_tdo = dr_q[0];
  end

  always_ff @(posedge tck_i) begin
    if (!trst_ni) begin
      ir_q        <= IrLength'(IDCODE);
      ir_shift_q  <= '0;
      dr_q        <= '0;
      bypass_q    <= 1'b0;
      td_q        <= 1'b0;
      oe_q        <= 1'b0;
      dmi_reset_q <= 1'b0;
    end else begin
      dmi_reset_q <= 1'b0;
      oe_q        <= testmode_i | sh_ir | sh_dr;

      if (cap_ir)     ir_shift_q <= IrLength'(IrCaptureValue);
      else if (sh_ir) ir_shift_q <= {td_i, ir_shift_q[IrLength-1:1]};

      if (tlr)         ir_q <= IrLength'(IDCODE);
      else if (upd_ir) ir_q <= ir_shift_q;

      if (cap_dr) begin
        bypass_q <= 1'b0;
        if (sel_idcode)     dr_q <= IdcodeValue | 32'h1;
        else if (sel_dtmcs) dr_q <= dtmcs_capture(dmi_error_i);
      end else if (sh_dr) begin
        bypass_q <= td_i;
        if (sel_idcode || sel_dtmcs) dr_q <= {td_i, dr_q[31:1]};
      end

      if (sh_ir)      td_q <= ir_shift_q[0];
      else if (sh_dr) td_q <= dr_tdo;

      if (upd_dr && sel_dtmcs) begin
        dmi_reset_q <= dr_q[DtmcsDmiresetBit];
`ifdef JTAG_TAP_DMIHARDRESET_EN
        if (dr_q[DtmcsDmihardresetBit]) begin
          dmi_reset_q <= 1'b1;
          ir_q        <= IrLength'(IDCODE);
        end
`endif
      end
    end
  end

  assign td_o               = td_q;
  assign tdo_oe_o           = oe_q;
  assign test_logic_reset_o = tlr;
  assign capture_dr_o       = cap_dr;
  assign shift_dr_o         = sh_dr;
  assign update_dr_o        = upd_dr;
  assign dmi_access_o       = sel_dmi;
  assign dtmcs_select_o     = sel_dtmcs;
  assign dmi_reset_o        = dmi_reset_q;
  assign dmi_tdi_o          = td_i;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb/tb_jtag_tap_ctrl.sv - scoreboard bench for jtag_tap_ctrl with random data
module tb_jtag_tap_ctrl;

  localparam logic [31:0] Idc = 32'h00000001;
  localparam logic [4:0]  CIdcode = 5'h01, CDtmcs = 5'h10, CDmi = 5'h11;

  logic       tck_i = 1'b0, trst_ni = 1'b0, tms_i = 1'b1, td_i = 1'b0;
  logic       testmode_i = 1'b0, dmi_tdo_i = 1'b0;
  logic [1:0] dmi_error_i = 2'b11;
  logic       td_o, tdo_oe_o, test_logic_reset_o, capture_dr_o, shift_dr_o, update_dr_o;
  logic       dmi_access_o, dtmcs_select_o, dmi_reset_o, dmi_tdi_o;

  jtag_tap_ctrl #(.IrLength(5), .IdcodeValue(Idc)) dut (
    .tck_i(tck_i), .trst_ni(trst_ni), .tms_i(tms_i), .td_i(td_i), .td_o(td_o),
    .tdo_oe_o(tdo_oe_o), .testmode_i(testmode_i), .test_logic_reset_o(test_logic_reset_o),
    .capture_dr_o(capture_dr_o), .shift_dr_o(shift_dr_o), .update_dr_o(update_dr_o),
    .dmi_access_o(dmi_access_o), .dtmcs_select_o(dtmcs_select_o), .dmi_reset_o(dmi_reset_o),
    .dmi_error_i(dmi_error_i), .dmi_tdi_o(dmi_tdi_o), .dmi_tdo_i(dmi_tdo_i)
  );

  always #5 tck_i = ~tck_i;

  int   checks = 0, failures = 0;
  int   upd_dr_cnt = 0;
  bit   mon_en = 1'b0;
  logic exp_q[$];
  logic [4:0] m_ir;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every cycle with the output enabled presents one serial bit.
  always @(posedge tck_i) begin
    #1;
    if (update_dr_o) upd_dr_cnt++;
    if (mon_en && tdo_oe_o && !testmode_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL td_o_unexpected actual=%b required=none", td_o);
      end else begin
        check("td_o", {31'b0, td_o}, {31'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // dtmcs read view from its field list, MSB to LSB.
  function automatic logic [31:0] dtmcs_word(input logic [1:0] err);
    return {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, err, 6'd7, 4'd1};
  endfunction

  function automatic bit is_wide(input logic [4:0] c);
    return (c == CIdcode) || (c == CDtmcs);
  endfunction

  task automatic tick(input logic tms, input logic tdi, input logic dtdo);
    @(negedge tck_i);
    tms_i = tms; td_i = tdi; dmi_tdo_i = dtdo;
    @(posedge tck_i);
    #1;
  endtask

  task automatic check_sel(input string tag);
    check({tag, "_dtmcs_sel"}, {31'b0, dtmcs_select_o}, {31'b0, m_ir == CDtmcs});
    check({tag, "_dmi_access"}, {31'b0, dmi_access_o}, {31'b0, m_ir == CDmi});
  endtask

  task automatic shift_ir(input logic [4:0] code);
    logic [4:0] cap;
    cap = 5'b00101;
    for (int i = 0; i < 5; i++) exp_q.push_back(cap[i]);
    tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    for (int i = 0; i < 5; i++) tick(i == 4, code[i], 0);
    tick(1, 0, 0);
    tick(0, 0, 0);
    m_ir = code;
    check_sel("ir");
  endtask

  // Shifts n bits of din through the selected DR; ends in RunTestIdle, or in PauseDr.
  task automatic shift_dr(input logic [63:0] din, input int n, input bit pause);
    logic [63:0] dt;
    logic [31:0] word, wr;
    logic        exp_rst, r1, r2;
    int          shcnt;
    dt = {$urandom, $urandom};
    word = (m_ir == CIdcode) ? (Idc | 32'h1) : dtmcs_word(dmi_error_i);
    wr = word;
    for (int i = 0; i < n; i++) begin
      if (m_ir == CDmi)   exp_q.push_back(dt[i]);
      else if (is_wide(m_ir)) begin
        if (i < 32) exp_q.push_back(word[i]);
        else        exp_q.push_back(din[i-32]);
        wr = {din[i], wr[31:1]};
      end else if (i == 0) exp_q.push_back(1'b0);
      else                 exp_q.push_back(din[i-1]);
    end
    shcnt = 0;
    tick(1, 0, 0); tick(0, 0, 0);
    tick(0, 0, 0); shcnt += int'(shift_dr_o);
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, din[i], dt[i]);
      shcnt += int'(shift_dr_o);
      if (i == 0) check("dmi_tdi", {31'b0, dmi_tdi_o}, {31'b0, din[0]});
    end
    check("shift_dr_cycles", shcnt, n);
    if (pause) begin
      tick(0, 0, 0);
    end else begin
      exp_rst = (m_ir == CDtmcs) && wr[16];
`ifdef JTAG_TAP_DMIHARDRESET_EN
      exp_rst = exp_rst || ((m_ir == CDtmcs) && wr[17]);
      if ((m_ir == CDtmcs) && wr[17]) m_ir = CIdcode;
`endif
      tick(1, 0, 0);
      tick(0, 0, 0); r1 = dmi_reset_o;
      tick(0, 0, 0); r2 = dmi_reset_o;
      check("dmi_reset_after_upd", {31'b0, r1}, {31'b0, exp_rst});
      check("dmi_reset_second", {31'b0, r2}, 32'd0);
      check_sel("dr");
    end
  endtask

  logic [63:0] d;
  int          u0;

  initial begin
    m_ir = CIdcode;
    trst_ni = 1'b0;
    tick(1, 0, 0); tick(0, 1, 1);
    check("rst_tlr", {31'b0, test_logic_reset_o}, 32'd1);
    check("rst_td_o", {31'b0, td_o}, 32'd0);
    check("rst_oe", {31'b0, tdo_oe_o}, 32'd0);
    check("rst_dmi_reset", {31'b0, dmi_reset_o}, 32'd0);
    check_sel("rst");
    trst_ni = 1'b1;
    tick(0, 0, 0);
    check("idle_tlr", {31'b0, test_logic_reset_o}, 32'd0);
    mon_en = 1'b1;

    d = {$urandom, $urandom};
    shift_dr(d, 32, 0);

    shift_ir(CDtmcs);
    d = {$urandom, $urandom}; d[17:16] = 2'b00;
    shift_dr(d, 32, 0);
    d = {$urandom, $urandom}; d[17:16] = 2'b01;
    shift_dr(d, 32, 0);
    d = {$urandom, $urandom}; d[17:16] = 2'b10;
    shift_dr(d, 32, 0);
    if (m_ir != CDtmcs) shift_ir(CDtmcs);
    dmi_error_i = 2'($urandom_range(0, 2));
    d = {$urandom, $urandom}; d[17:16] = 2'b00;
    shift_dr(d, 32, 0);

    shift_ir(CDmi);
    shift_dr({$urandom, $urandom}, 41, 0);

    shift_ir(5'h07);
    shift_dr({$urandom, $urandom}, 8, 0);
    shift_ir(5'h00);
    shift_dr({$urandom, $urandom}, 6, 0);
    shift_ir(5'h1F);
    shift_dr({$urandom, $urandom}, 5, 0);
    for (int k = 0; k < 3; k++) begin
      logic [4:0] c;
      c = 5'($urandom_range(2, 15));
      shift_ir(c);
      shift_dr({$urandom, $urandom}, 3 + k, 0);
    end
    shift_ir(CIdcode);
    shift_dr({$urandom, $urandom}, 40, 0);

    // Five TMS=1 from PauseDr: Exit2Dr, UpdateDr, SelectDrScan, SelectIrScan, TestLogicReset.
    shift_ir(CDtmcs);
    d = {$urandom, $urandom}; d[17:16] = 2'b00;
    shift_dr(d, 32, 1);
    u0 = upd_dr_cnt;
    for (int i = 0; i < 5; i++) tick(1, 0, 0);
    check("pause_tlr", {31'b0, test_logic_reset_o}, 32'd1);
    check("pause_upd_count", upd_dr_cnt - u0, 1);
    tick(0, 0, 0);
    m_ir = CIdcode;
    check_sel("pause");
    shift_dr({$urandom, $urandom}, 32, 0);

    // Reset in the middle of a dtmcs shift carrying dmireset=1.
    shift_ir(CDtmcs);
    d = dtmcs_word(dmi_error_i);
    for (int i = 0; i < 20; i++) exp_q.push_back(d[i]);
    tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    for (int i = 0; i < 20; i++) tick(0, 1, 0);
    u0 = upd_dr_cnt;
    trst_ni = 1'b0;
    tick(0, 1, 0);
    check("midrst_tlr", {31'b0, test_logic_reset_o}, 32'd1);
    check("midrst_oe", {31'b0, tdo_oe_o}, 32'd0);
    check("midrst_td_o", {31'b0, td_o}, 32'd0);
    trst_ni = 1'b1;
    tick(0, 0, 0);
    tick(0, 0, 0);
    check("midrst_dmi_reset", {31'b0, dmi_reset_o}, 32'd0);
    check("midrst_upd_count", upd_dr_cnt - u0, 0);
    m_ir = CIdcode;
    check_sel("midrst");

    // Random TMS walks, then five TMS=1 must land in TestLogicReset.
    for (int k = 0; k < 4; k++) begin
      mon_en = 1'b0;
      for (int i = 0; i < 25; i++) tick(1'($urandom), 1'($urandom), 1'($urandom));
      for (int i = 0; i < 5; i++) tick(1, 0, 0);
      check("walk_tlr", {31'b0, test_logic_reset_o}, 32'd1);
      tick(0, 0, 0);
      tick(0, 0, 0);
      exp_q.delete();
      m_ir = CIdcode;
      check_sel("walk");
      mon_en = 1'b1;
    end
    shift_dr({$urandom, $urandom}, 33, 0);

    testmode_i = 1'b1;
    tick(0, 0, 0);
    check("testmode_oe", {31'b0, tdo_oe_o}, 32'd1);
    testmode_i = 1'b0;
    tick(0, 0, 0);
    check("testmode_off_oe", {31'b0, tdo_oe_o}, 32'd0);

    tick(0, 0, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
